// File: rtl/adsr_envelope_pkg.sv
// adsr_envelope_pkg
//   Shared constants for the voice datapath: sample width, default
//   envelope resolution and the ADSR state encoding.
//   No ports.
package adsr_envelope_pkg;

   localparam int unsigned SYNTH_WIDTH  = 16;
   localparam int unsigned ENV_BITS_DEF = 16;

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_ATTACK  = 3'd1;
   localparam logic [2:0] ST_DECAY   = 3'd2;
   localparam logic [2:0] ST_SUSTAIN = 3'd3;
   localparam logic [2:0] ST_RELEASE = 3'd4;

   typedef enum logic [2:0] {
      IDLE    = ST_IDLE,
      ATTACK  = ST_ATTACK,
      DECAY   = ST_DECAY,
      SUSTAIN = ST_SUSTAIN,
      RELEASE = ST_RELEASE
   } env_state_t;

endpackage

// File: rtl/adsr_envelope_if.sv
// adsr_envelope_if
//   Bundles the envelope control inputs, the oscillator sample stream and
//   the envelope/VCA outputs of one voice.
//   slave  : envelope side (gate/tick/rates/sample in; val/env/active out)
//   master : controller side (mirror of slave)
interface adsr_envelope_if #(
   parameter int unsigned SYNTH_WIDTH = adsr_envelope_pkg::SYNTH_WIDTH,
   parameter int unsigned ENV_BITS    = adsr_envelope_pkg::ENV_BITS_DEF
);

   logic                          gate_in;
   logic                          tick_in;
   logic [ENV_BITS-1:0]           attack_step_in;
   logic [ENV_BITS-1:0]           decay_step_in;
   logic [ENV_BITS-1:0]           sustain_level_in;
   logic [ENV_BITS-1:0]           release_step_in;
   logic signed [SYNTH_WIDTH-1:0] sample_in;
   logic signed [SYNTH_WIDTH-1:0] val_out;
   logic [ENV_BITS-1:0]           env_out;
   logic                          active_out;

   modport slave (
      input  gate_in, tick_in, attack_step_in, decay_step_in,
             sustain_level_in, release_step_in, sample_in,
      output val_out, env_out, active_out
   );

   modport master (
      output gate_in, tick_in, attack_step_in, decay_step_in,
             sustain_level_in, release_step_in, sample_in,
      input  val_out, env_out, active_out
   );

endinterface

// File: rtl/adsr_envelope_vca.sv
// adsr_envelope_vca
//   Registered signed amplifier: val = floor(sample * gain / 2^GAIN_W).
//   Gain is unsigned and strictly below 1, so the result always fits
//   SAMPLE_W bits. Latency: inputs captured at edge t, val_out at t+2.
//   clk_in, rst_in : clock, synchronous active-high reset
//   sample_in      : signed sample
//   gain_in        : unsigned gain
//   val_out        : scaled signed sample
module adsr_envelope_vca #(
   parameter int unsigned SAMPLE_W = 16,
   parameter int unsigned GAIN_W   = 16
) (
   input  logic                       clk_in,
   input  logic                       rst_in,
   input  logic signed [SAMPLE_W-1:0] sample_in,
   input  logic [GAIN_W-1:0]          gain_in,
   output logic signed [SAMPLE_W-1:0] val_out
);

   localparam int unsigned PW = SAMPLE_W + GAIN_W + 1;

   logic signed [SAMPLE_W-1:0] sample_q;
   logic [GAIN_W-1:0]          gain_q;
   logic signed [PW-1:0]       prod_q;

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         sample_q <= '0;
         gain_q   <= '0;
         prod_q   <= '0;
         val_out  <= '0;
      end else begin
         sample_q <= sample_in;
         gain_q   <= gain_in;
         // zero-extended gain keeps the multiply signed without flipping sign
         prod_q   <= PW'(sample_q) * PW'($signed({1'b0, gain_q}));
         val_out  <= SAMPLE_W'(prod_q >>> GAIN_W);
      end
   end

endmodule

// File: rtl/adsr_envelope.sv
// adsr_envelope
//   Per-voice ADSR envelope generator feeding a built-in VCA.
//   clk_in, rst_in : clock, synchronous active-high reset
//   bus (slave)    : gate_in, tick_in, attack/decay/release steps,
//                    sustain_level_in, sample_in -> val_out, env_out,
//                    active_out
//   Gate events act every cycle; envelope arithmetic only on tick_in.
module adsr_envelope
   import adsr_envelope_pkg::*;
#(
   parameter int unsigned ENV_BITS = ENV_BITS_DEF
) (
   input  logic           clk_in,
   input  logic           rst_in,
   adsr_envelope_if.slave bus
);

   localparam logic [ENV_BITS-1:0] ENV_MAX = '1;

   env_state_t          state_q, state_d;
   logic [ENV_BITS-1:0] env_q, env_d;
   logic                gate_q;
   logic                active_q;
   logic                rise;
   logic [ENV_BITS:0]   att_sum;
   logic [ENV_BITS:0]   dec_floor;

   always_comb begin
      rise      = bus.gate_in & ~gate_q;
      att_sum   = {1'b0, env_q} + {1'b0, bus.attack_step_in};
      dec_floor = {1'b0, bus.sustain_level_in} + {1'b0, bus.decay_step_in};
      state_d   = state_q;
      env_d     = env_q;

      // gate events take priority over a coincident tick and leave env alone
      if (rise) begin
         state_d = ATTACK;
      end else if (!bus.gate_in &&
                   (state_q inside {ATTACK, DECAY, SUSTAIN})) begin
         state_d = RELEASE;
      end else if (bus.tick_in) begin
         unique case (state_q)
            IDLE: env_d = '0;
            ATTACK: begin
               if (att_sum >= {1'b0, ENV_MAX}) begin
                  env_d   = ENV_MAX;
                  state_d = DECAY;
               end else begin
                  env_d = att_sum[ENV_BITS-1:0];
               end
            end
            DECAY: begin
               // also snaps upward when sustain sits above env
               if ({1'b0, env_q} <= dec_floor) begin
                  env_d   = bus.sustain_level_in;
                  state_d = SUSTAIN;
               end else begin
                  env_d = env_q - bus.decay_step_in;
               end
            end
            SUSTAIN: env_d = bus.sustain_level_in;
            RELEASE: begin
               if (env_q <= bus.release_step_in) begin
                  env_d   = '0;
                  state_d = IDLE;
               end else begin
                  env_d = env_q - bus.release_step_in;
               end
            end
            default: begin
               env_d   = '0;
               state_d = IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state_q  <= IDLE;
         env_q    <= '0;
         gate_q   <= 1'b0;
         active_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         env_q    <= env_d;
         gate_q   <= bus.gate_in;
         active_q <= (state_d != IDLE);
      end
   end

   assign bus.env_out    = env_q;
   assign bus.active_out = active_q;

   adsr_envelope_vca #(
      .SAMPLE_W (SYNTH_WIDTH),
      .GAIN_W   (ENV_BITS)
   ) u_vca (
      .clk_in    (clk_in),
      .rst_in    (rst_in),
      .sample_in (bus.sample_in),
      .gain_in   (env_q),
      .val_out   (bus.val_out)
   );

endmodule

// File: doc/adsr_envelope.md
# adsr_envelope

Per-voice ADSR envelope generator with a built-in amplifier (VCA). Sits directly downstream of the oscillator stage: takes the oscillator's signed sample stream, scales it by a 5-state attack/decay/sustain/release envelope driven by a note gate, and presents the scaled sample to the voice mixer. Envelope rates are programmed as per-tick step sizes; envelope updates occur only on a sample-rate tick strobe.

## Interface

Parameters:
- ENV_BITS, 16, unsigned envelope resolution; gain = env / 2^ENV_BITS

Ports:
- clk_in  in  1  system clock
- rst_in  in  1  reset, synchronous, active-high
- gate_in  in  1  note gate; high = key held
- tick_in  in  1  single-cycle envelope update strobe (sample rate)
- attack_step_in  in  ENV_BITS  env increment per tick in ATTACK
- decay_step_in  in  ENV_BITS  env decrement per tick in DECAY
- sustain_level_in  in  ENV_BITS  SUSTAIN target level
- release_step_in  in  ENV_BITS  env decrement per tick in RELEASE
- sample_in  in  SYNTH_WIDTH signed  oscillator sample, valid every cycle
- val_out  out  SYNTH_WIDTH signed  scaled sample
- env_out  out  ENV_BITS  current envelope register
- active_out  out  1  high whenever state != IDLE (for voice allocator)

## Operation

- States: IDLE, ATTACK, DECAY, SUSTAIN, RELEASE. ENV_MAX = 2^ENV_BITS-1.
- gate_in registered internally (gate_q); rising edge = gate_in & ~gate_q.
- Gate events evaluated every cycle, independent of tick_in:
  - rising edge, any state -> ATTACK; env retained (retrigger without click).
  - gate_in low in ATTACK/DECAY/SUSTAIN -> RELEASE; env retained.
- Gate event and tick_in in the same cycle: transition only, env unchanged that cycle.
- On tick_in, no gate event:
  - IDLE: env = 0.
  - ATTACK: sum in ENV_BITS+1 bits; if env + attack_step >= ENV_MAX then env = ENV_MAX, -> DECAY; else env += attack_step. attack_step = 0 holds env (legal).
  - DECAY: if env <= sustain_level_in + decay_step (compared without wrap, ENV_BITS+1 bits) then env = sustain_level_in, -> SUSTAIN; else env -= decay_step.
  - SUSTAIN: env = sustain_level_in (live edits tracked, step change permitted).
  - RELEASE: if env <= release_step then env = 0, -> IDLE; else env -= release_step.
- Sustain level above env at DECAY entry: first DECAY tick snaps env to sustain_level_in.
- VCA: product = sample_in × {1'b0, env} (signed, SYNTH_WIDTH+ENV_BITS+1 bits); val_out = product >>> ENV_BITS, truncated to SYNTH_WIDTH (cannot overflow, gain < 1; arithmetic shift floors toward −∞).

## Timing

- Reset: state IDLE, env_out 0, gate_q 0, active_out 0, both pipeline registers and val_out 0. rst_in mid-note overrides everything in the same edge; a gate held high through reset release produces a rising edge on the first post-reset cycle only if gate_q was cleared (it is), so the note restarts.
- env_out, active_out: registered; update on the edge after the causing tick/gate cycle.
- VCA latency 2 cycles: sample_in and env_out sampled at edge t into stage-1 registers; product registered at t+1; val_out valid after edge t+2. No handshake; new sample every cycle.

## Structure

- ENV_BITS default and state enum (env_state_t) go in the shared constants package alongside SYNTH_WIDTH.
- One sub-module natural: vca (2-stage registered signed multiply + shift), reusable by filter/mixer stages. State machine and env register stay in adsr_envelope.

## Test plan

Bench built with SYNTH_WIDTH=16, ENV_BITS=16.
- Reset: rst_in 3 cycles with gate high, sample 1000 -> val_out 0, env_out 0, active_out 0; after release ATTACK entered next cycle.
- Attack: attack_step 0x4000, gate high, tick every cycle -> env 0x4000, 0x8000, 0xC000, 0xFFFF, state DECAY at 0xFFFF.
- Decay/sustain: decay_step 0x1000, sustain 0xC000 -> 0xEFFF, 0xDFFF, 0xCFFF, 0xC000, SUSTAIN; sustain changed to 0x8000 -> env 0x8000 next tick.
- Release: gate low at env 0x8000, release_step 0x3000 -> 0x5000, 0x2000, 0x0000, IDLE, active_out falls.
- Retrigger: gate rises at env 0x5000 in RELEASE with tick same cycle -> ATTACK, env stays 0x5000 that cycle, then 0x9000 on next tick.
- VCA: env held 0x8000, sample_in 16384 -> val_out 8192 two cycles later; -32768 -> -16384; -1 -> -1; env 0 -> 0.
